mul_pipe_stage: RTL and testbench
=================================

MUL_PIPE_STAGE -- requirements
Module: mul_pipe_stage

Interface
REQ-001 Parameter TAG_W, default 5, SHALL set the width of the destination-register tag.
REQ-002 Parameter PERF_W, default 16, SHALL set the width of the completion counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be a synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  SHALL mark a multiply request from decode.
REQ-006 in_ready  output  1  SHALL mark that the stage accepts a request this cycle.
REQ-007 in_a, in_b  input  32 each  SHALL carry the signed multiplicand and multiplier.
REQ-008 in_rd  input  TAG_W  SHALL carry the destination tag.
REQ-009 flush  input  1  SHALL kill all in-flight requests.
REQ-010 wb_valid  output  1  SHALL mark a valid result.
REQ-011 wb_ready  input  1  SHALL mark that writeback consumes the result.
REQ-012 wb_data  output  32  SHALL carry the low 32 bits of in_a*in_b.
REQ-013 wb_rd  output  TAG_W  SHALL carry the tag of wb_data.
REQ-014 busy  output  1  SHALL be high while any pipeline slot is occupied.
REQ-015 perf_cnt  output  PERF_W  SHALL report the completed-operation count.

Function
REQ-016 Structure: S1 operand register (a_q, b_q, rd_q, v1); combinational instance of mul_tree32 on a_q/b_q; S2 result register (wb_data, wb_rd, v2 = wb_valid).
REQ-017 Occupancy states: EMPTY (v1=0,v2=0), HEAD (v1=0,v2=1), TAIL (v1=1,v2=0), FULL (v1=1,v2=1); transitions follow REQ-018..REQ-020 only.
REQ-018 adv2 = v1 & (~v2 | wb_ready); on adv2, S2 loads the product and rd_q and v2 is set; if ~v1 & wb_ready, v2 clears.
REQ-019 in_ready = ~flush & (~v1 | adv2), combinational; on in_valid & in_ready, S1 loads in_a/in_b/in_rd and v1 is set; if adv2 without acceptance, v1 clears.
REQ-020 Latency: an accepted request SHALL present wb_valid exactly 2 cycles later when wb_ready stays high; throughput is 1 per cycle.
REQ-021 Backpressure: while wb_valid & ~wb_ready, wb_data and wb_rd SHALL hold stable; S1 holds and in_ready is low in FULL.
REQ-022 Arithmetic: wb_data SHALL equal bits [31:0] of the two's-complement product; overflow is ignored.
REQ-023 Flush: wb_valid & wb_ready in the flush cycle SHALL complete normally; v1 and v2 SHALL both be 0 on the following edge; in_ready is low during flush.
REQ-024 busy = v1 | v2.
REQ-025 Ordering: results SHALL leave in acceptance order; no request is dropped except by flush or reset.

Reset
REQ-026 With rst_n low at an edge: v1=0, v2=0, wb_data=0, wb_rd=0, a_q=b_q=0, perf_cnt=0; in-flight operations are discarded.
REQ-027 in_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release (EMPTY).

Configuration
REQ-028 Macro MUL_PERF_CNT_EN defined: perf_cnt increments by 1 on each wb_valid & wb_ready and saturates at all-ones.
REQ-029 Macro MUL_PERF_CNT_EN undefined: no counter register; perf_cnt is constant 0.

Verification
REQ-030 Reset, then in_a=7, in_b=-3, in_rd=4, wb_ready=1 -> wb_valid at cycle +2, wb_data=0xFFFFFFEB, wb_rd=4.
REQ-031 in_a=0x80000000, in_b=0xFFFFFFFF -> wb_data=0x80000000; in_a=0x00010000, in_b=0x00010000 -> wb_data=0.
REQ-032 4 back-to-back requests (tags 1..4) with wb_ready held low 5 cycles -> in_ready low once FULL; tags 1..4 emerge in order with data stable while stalled.
REQ-033 flush asserted in FULL with in_valid=1 -> no acceptance; next cycle busy=0, wb_valid=0; a new request then completes in 2 cycles.
REQ-034 rst_n low for 1 cycle while FULL -> all outputs 0 next cycle; perf_cnt=0.
REQ-035 MUL_PERF_CNT_EN, PERF_W=4, 17 completions -> perf_cnt=15 (saturated); without the macro, perf_cnt=0 throughout.

Source files
------------

// File: rtl/mul_pipe_stage.sv
// Purpose : two-stage 32x32 multiply stage (operand reg -> tree multiplier -> result reg).
// Latency : 2 cycles from accept to wb_valid with writeback ready; 1 request/cycle throughput.
// Backpressure: wb_ready low holds the result; in_ready drops only when both slots are full.
//
// Ports:
//   clk, rst_n           single clock, synchronous active-low reset
//   in_valid/in_ready    request handshake; in_a, in_b signed operands, in_rd destination tag
//   flush                kills both pipeline slots (results handed off this cycle still count)
//   wb_valid/wb_ready    result handshake; wb_data low 32 bits of product, wb_rd its tag
//   busy                 any slot occupied
//   perf_cnt             saturating completion count, present only with MUL_PERF_CNT_EN defined
//                        (constant zero otherwise)

// Combinational low-32 multiplier: partial products summed in a binary adder tree.
// Only the low 32 bits are kept, so unsigned partial products give the signed result too.
module mul_tree32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);
    logic [31:0] lvl [6][32];

    always_comb begin
        for (int l = 0; l < 6; l++) begin
            for (int i = 0; i < 32; i++) begin
                lvl[l][i] = '0;
            end
        end
        for (int i = 0; i < 32; i++) begin
            lvl[0][i] = b[i] ? (a << i) : 32'd0;
        end
        for (int l = 1; l < 6; l++) begin
            for (int i = 0; i < (32 >> l); i++) begin
                lvl[l][i] = lvl[l-1][2*i] + lvl[l-1][2*i+1];
            end
        end
    end

    assign p = lvl[5][0];
endmodule

module mul_pipe_stage #(
    parameter int TAG_W  = 5,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic [TAG_W-1:0]  in_rd,
    input  logic              flush,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [31:0]       wb_data,
    output logic [TAG_W-1:0]  wb_rd,
    output logic              busy,
    output logic [PERF_W-1:0] perf_cnt
);
    // S1 operand slot
    logic             v1_q, v1_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0] rd_q, rd_d;
    // S2 result slot
    logic             v2_q, v2_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [TAG_W-1:0] wb_rd_q, wb_rd_d;

    logic [31:0] prod;
    logic        adv2;
    logic        accept;
    logic        wb_fire;

    mul_tree32 u_mul (
        .a (a_q),
        .b (b_q),
        .p (prod)
    );

    // S1 may move forward when S2 is empty or being drained this cycle.
    assign adv2    = v1_q & (~v2_q | wb_ready);
    // Gated by rst_n so nothing is accepted while the pipeline is being cleared.
    assign in_ready = rst_n & ~flush & (~v1_q | adv2);
    assign accept  = in_valid & in_ready;
    assign wb_fire = v2_q & wb_ready;

    always_comb begin
        v1_d      = v1_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        v2_d      = v2_q;
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;

        if (accept) begin
            a_d  = in_a;
            b_d  = in_b;
            rd_d = in_rd;
            v1_d = 1'b1;
        end else if (adv2) begin
            v1_d = 1'b0;
        end

        if (adv2 && !flush) begin
            wb_data_d = prod;
            wb_rd_d   = rd_q;
            v2_d      = 1'b1;
        end else if (wb_fire) begin
            v2_d = 1'b0;
        end

        // A handshake in the flush cycle has already completed; everything else dies.
        if (flush) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            v2_q      <= 1'b0;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
        end else begin
            v1_q      <= v1_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rd_q      <= rd_d;
            v2_q      <= v2_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
        end
    end

    assign wb_valid = v2_q;
    assign wb_data  = wb_data_q;
    assign wb_rd    = wb_rd_q;
    assign busy     = v1_q | v2_q;

`ifdef MUL_PERF_CNT_EN
    logic [PERF_W-1:0] perf_q, perf_d;

    // Saturates at all-ones rather than wrapping.
    always_comb begin
        perf_d = perf_q;
        if (wb_fire && (perf_q != {PERF_W{1'b1}})) begin
            perf_d = perf_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cnt = perf_q;
`else
    assign perf_cnt = '0;
`endif
endmodule

// File: tb/tb_mul_pipe_stage.sv
module tb_mul_pipe_stage;
    localparam int TW = 5;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_a, in_b;
    logic [TW-1:0] in_rd;
    logic          flush;
    logic          wb_valid;
    logic          wb_ready;
    logic [31:0]   wb_data;
    logic [TW-1:0] wb_rd;
    logic          busy;
    logic [PW-1:0] perf_cnt;

    always #5 clk = ~clk;

    mul_pipe_stage #(.TAG_W(TW), .PERF_W(PW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_rd    (in_rd),
        .flush    (flush),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_data  (wb_data),
        .wb_rd    (wb_rd),
        .busy     (busy),
        .perf_cnt (perf_cnt)
    );

    typedef struct {
        logic [31:0]   a;
        logic [31:0]   b;
        logic [TW-1:0] rd;
    } req_t;

    typedef struct {
        logic [31:0]   d;
        logic [TW-1:0] rd;
        int            rdy_at;
    } item_t;

    // Reference model: requests waiting to be offered, and results in flight in acceptance order.
    req_t  pend[$];
    item_t q[$];
    int    cyc;
    int    perf_m;
    bit    chk_en;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint      pa, pb;
        logic [63:0] pv;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        pv = pa * pb;
        return pv[31:0];
    endfunction

    task automatic add_req(input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] rd);
        req_t r;
        r.a = a; r.b = b; r.rd = rd;
        pend.push_back(r);
    endtask

    // One clock cycle: drive, check against the model, clock, advance the model.
    task automatic tick();
        logic  exp_v, exp_rdy;
        item_t it;
        in_valid = (pend.size() != 0);
        if (in_valid) begin
            in_a  = pend[0].a;
            in_b  = pend[0].b;
            in_rd = pend[0].rd;
        end else begin
            in_a  = $urandom;
            in_b  = $urandom;
            in_rd = TW'($urandom);
        end
        #1;
        exp_v   = (q.size() != 0) && (q[0].rdy_at <= cyc);
        exp_rdy = rst_n && !flush && ((q.size() < 2) || wb_ready);
        if (chk_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            chk("wb_valid", {31'd0, wb_valid}, {31'd0, exp_v});
            chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
            chk("perf_cnt", {28'd0, perf_cnt}, perf_m);
            if (exp_v) begin
                chk("wb_data", wb_data, q[0].d);
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, q[0].rd});
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            perf_m = 0;
        end else begin
            if (exp_v && wb_ready) begin
                void'(q.pop_front());
`ifdef MUL_PERF_CNT_EN
                if (perf_m < (1 << PW) - 1) perf_m++;
`endif
            end
            if (in_valid && exp_rdy) begin
                it.d      = ref_mul(pend[0].a, pend[0].b);
                it.rd     = pend[0].rd;
                it.rdy_at = cyc + 2;
                q.push_back(it);
                void'(pend.pop_front());
            end
            if (flush) q.delete();
        end
        cyc++;
        #1;
    endtask

    initial begin
        int drain;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_rd = '0;
        flush = 1'b0; wb_ready = 1'b0;
        cyc = 0; perf_m = 0; chk_en = 1'b0;

        // Reset
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // 7 * -3, tag 4, latency 2
        wb_ready = 1'b1;
        add_req(32'd7, 32'hFFFFFFFD, 5'd4);
        tick();
        tick();
        chk("lat_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("lat_wb_data", wb_data, 32'hFFFFFFEB);
        chk("lat_wb_rd", {27'd0, wb_rd}, 32'd4);
        tick();

        // Overflow corner cases, back to back
        add_req(32'h80000000, 32'hFFFFFFFF, 5'd9);
        add_req(32'h00010000, 32'h00010000, 5'd10);
        tick();
        tick();
        chk("ovf_min_neg", wb_data, 32'h80000000);
        tick();
        chk("ovf_wrap_zero", wb_data, 32'd0);
        tick();
        tick();

        // Four requests against a 5-cycle writeback stall
        wb_ready = 1'b0;
        for (int t = 1; t <= 4; t++) add_req($urandom, $urandom, TW'(t));
        for (int i = 0; i < 5; i++) tick();
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_head_rd", {27'd0, wb_rd}, 32'd1);
        wb_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        // Flush while full with a request offered
        wb_ready = 1'b0;
        for (int t = 11; t <= 13; t++) add_req($urandom, $urandom, TW'(t));
        for (int i = 0; i < 3; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
        wb_ready = 1'b1;
        tick();
        tick();
        chk("post_flush_valid", {31'd0, wb_valid}, 32'd1);
        chk("post_flush_rd", {27'd0, wb_rd}, 32'd13);
        tick();

        // Reset while full
        wb_ready = 1'b0;
        add_req($urandom, $urandom, 5'd20);
        add_req($urandom, $urandom, 5'd21);
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rstfull_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rstfull_wb_data", wb_data, 32'd0);
        chk("rstfull_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rstfull_busy", {31'd0, busy}, 32'd0);
        chk("rstfull_perf", {28'd0, perf_cnt}, 32'd0);
        chk("rstfull_in_ready", {31'd0, in_ready}, 32'd1);

        // Randomized traffic: enough completions to saturate the counter
        for (int i = 0; i < 300; i++) begin
            if (pend.size() < 2 && ($urandom % 10) < 7) begin
                case ($urandom % 4)
                    0:       add_req(32'h80000000, $urandom, TW'($urandom));
                    1:       add_req($urandom, 32'hFFFFFFFF, TW'($urandom));
                    default: add_req($urandom, $urandom, TW'($urandom));
                endcase
            end
            wb_ready = (($urandom % 4) != 0);
            flush    = (($urandom % 40) == 0);
            tick();
        end

        // Drain with a bounded cycle budget
        flush = 1'b0;
        wb_ready = 1'b1;
        drain = 0;
        while ((pend.size() != 0 || q.size() != 0) && drain < 20) begin
            tick();
            drain++;
        end
        tick();
        chk("drain_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
